irq_ctl: RTL and testbench

Interrupt controller that drives the core's single `irq` request and consumes `iack`, the other end of the core control FSM's interrupt handshake. It synchronises up to eight external sources, latches them as pending per source in edge or level mode, and masks them. It then presents the lowest-numbered enabled pending source as `vec_id` and sequences one request per service. A small four-register bus port gives software access to the pending, mask, mode and status state.

---
 rtl/irq_ctl.sv | 118 +++++++++++
 tb/tb_irq_ctl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctl.sv
// Interrupt controller: synchronises sources, latches them as pending per source in edge
// or level mode, masks them and sequences one irq/iack handshake per service.
module irq_ctl #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_in,
   output logic             irq,
   input  logic             iack,
   output logic [2:0]       vec_id,
   input  logic             wr_en,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t           state;
   logic [N_SRC-1:0] s1, s2, s3;
   logic [N_SRC-1:0] pend, mask, mode;
   logic [N_SRC-1:0] req, edge_ev, w1c, ack_clr;
   logic [2:0]       sel;
   logic             unused_wdata;

   assign unused_wdata = ^wdata[31:N_SRC];

   always_comb begin
      edge_ev = s2 & ~s3;
      req     = pend & mask;
      w1c     = (wr_en && addr == 2'd0) ? wdata[N_SRC-1:0] : '0;
      sel     = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) sel = 3'(i);
      end
      ack_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = (state == ASSERT) && iack && (vec_id == 3'(i)) && mode[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= src_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Edge bits: a new edge beats any clear in the same cycle. Level bits mirror s2.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend <= '0;
         mask <= '0;
         mode <= '1;
      end else begin
         pend <= (mode & ((pend & ~(w1c | ack_clr)) | edge_ev)) | (~mode & s2);
         if (wr_en && addr == 2'd1) mask <= wdata[N_SRC-1:0];
         if (wr_en && addr == 2'd2) mode <= wdata[N_SRC-1:0];
      end
   end

   // irq stays high in ASSERT regardless of mask/pend changes until the core acknowledges.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         irq    <= 1'b0;
         vec_id <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req != '0) begin
                  vec_id <= sel;
                  irq    <= 1'b1;
                  state  <= ASSERT;
               end
            end
            ASSERT: begin
               if (iack) begin
                  irq   <= 1'b0;
                  state <= SERVICE;
               end
            end
            SERVICE: begin
               if (!iack) state <= DRAIN;
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               irq   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         2'd0: rdata[N_SRC-1:0] = pend;
         2'd1: rdata[N_SRC-1:0] = mask;
         2'd2: rdata[N_SRC-1:0] = mode;
         default: rdata[6:0] = {iack, irq, state, vec_id};
      endcase
   end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: reset, edge request, priority, level mode,
// set/clear collision with masking, and reset during service.
module tb_irq_ctl;

   logic        clk;
   logic        rst;
   logic [7:0]  src_in;
   logic        irq;
   logic        iack;
   logic [2:0]  vec_id;
   logic        wr_en;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_err = 0;

   irq_ctl #(.N_SRC(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .src_in (src_in),
      .irq    (irq),
      .iack   (iack),
      .vec_id (vec_id),
      .wr_en  (wr_en),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next active edge; outputs then reflect that edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      tick();
      wr_en = 1'b0;
      wdata = '0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic wait_irq(input int max, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         tick();
         if (irq === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s: irq not seen within %0d cycles", name, max);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b0;
      ticks(2);
      rst = 1'b1;
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
      n_cmp++;
      if (vec_id !== 3'd0) begin n_err++; $display("FAIL reset_vec: got %0d want 0", vec_id); end
      read_reg(2'd3, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL reset_stat: got %h want 00", d); end
      read_reg(2'd2, d);
      n_cmp++;
      if (d !== 32'hFF) begin n_err++; $display("FAIL reset_mode: got %h want ff", d); end
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL reset_pend: got %h want 00", d); end
      read_reg(2'd1, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL reset_mask: got %h want 00", d); end
   endtask

   task automatic test_edge_basic();
      logic [31:0] d;
      int          hits;
      bus_write(2'd1, 32'h08);
      src_in = 8'h08;
      tick();                       // edge k
      src_in = 8'h00;
      ticks(2);                     // k+1, k+2
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL edge_early: irq %b at k+2 want 0", irq); end
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h08) begin n_err++; $display("FAIL edge_pend: got %h want 08", d); end
      tick();                       // k+3
      n_cmp++;
      if (irq !== 1'b1 || vec_id !== 3'd3) begin
         n_err++; $display("FAIL edge_latency: irq %b vec %0d want 1/3", irq, vec_id);
      end
      read_reg(2'd3, d);
      n_cmp++;
      if (d !== 32'h2B) begin n_err++; $display("FAIL edge_stat: got %h want 2b", d); end
      iack = 1'b1;
      tick();
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL edge_ack_irq: got %b want 0", irq); end
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL edge_ack_pend: got %h want 00", d); end
      hits = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (irq !== 1'b0) hits++; end
      iack = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(); if (irq !== 1'b0) hits++; end
      n_cmp++;
      if (hits != 0) begin n_err++; $display("FAIL edge_no_second: irq high %0d cycles want 0", hits); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      bus_write(2'd1, 32'hFF);
      src_in = 8'h24;
      tick();
      src_in = 8'h00;
      wait_irq(10, "prio_first");
      n_cmp++;
      if (vec_id !== 3'd2) begin n_err++; $display("FAIL prio_vec_first: got %0d want 2", vec_id); end
      iack = 1'b1;
      tick();
      iack = 1'b0;
      ticks(2);                     // r, r+1
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL prio_gap: irq %b at r+1 want 0", irq); end
      tick();                       // r+2
      n_cmp++;
      if (irq !== 1'b1 || vec_id !== 3'd5) begin
         n_err++; $display("FAIL prio_second: irq %b vec %0d want 1/5", irq, vec_id);
      end
      iack = 1'b1;
      tick();
      iack = 1'b0;
      ticks(3);
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL prio_pend_end: got %h want 00", d); end
      bus_write(2'd1, 32'h00);
   endtask

   task automatic test_level();
      logic [31:0] d;
      int          hits;
      bus_write(2'd2, 32'hFE);
      bus_write(2'd1, 32'h01);
      src_in = 8'h01;
      wait_irq(10, "level_first");
      n_cmp++;
      if (vec_id !== 3'd0) begin n_err++; $display("FAIL level_vec: got %0d want 0", vec_id); end
      iack = 1'b1;
      tick();
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h01) begin n_err++; $display("FAIL level_pend_ack: got %h want 01", d); end
      bus_write(2'd0, 32'h01);
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h01) begin n_err++; $display("FAIL level_w1c: got %h want 01", d); end
      iack = 1'b0;
      ticks(3);
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL level_reassert: got %b want 1", irq); end
      iack = 1'b1;
      tick();
      src_in = 8'h00;
      ticks(4);
      iack = 1'b0;
      hits = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (irq !== 1'b0) hits++; end
      n_cmp++;
      if (hits != 0) begin n_err++; $display("FAIL level_drop: irq high %0d cycles want 0", hits); end
      bus_write(2'd1, 32'h00);
      bus_write(2'd2, 32'hFF);
   endtask

   task automatic test_set_clear_mask();
      logic [31:0] d;
      int          hits;
      src_in = 8'h02;
      tick();                       // edge k
      src_in = 8'h00;
      tick();                       // k+1
      bus_write(2'd0, 32'h02);      // W1C lands on k+2, same edge as the set
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h02) begin n_err++; $display("FAIL setclr_pend: got %h want 02", d); end
      hits = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (irq !== 1'b0) hits++; end
      n_cmp++;
      if (hits != 0) begin n_err++; $display("FAIL masked_no_irq: irq high %0d cycles want 0", hits); end
      bus_write(2'd1, 32'h02);      // edge w
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL unmask_early: irq %b at w want 0", irq); end
      tick();                       // w+1
      n_cmp++;
      if (irq !== 1'b1 || vec_id !== 3'd1) begin
         n_err++; $display("FAIL unmask_irq: irq %b vec %0d want 1/1", irq, vec_id);
      end
      bus_write(2'd1, 32'h00);
      ticks(3);
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL no_withdraw: got %b want 1", irq); end
      iack = 1'b1;
      tick();
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL withdraw_ack: got %b want 0", irq); end
      iack = 1'b0;
      ticks(3);
   endtask

   task automatic test_reset_mid_service();
      logic [31:0] d;
      int          bad;
      bus_write(2'd1, 32'h05);
      src_in = 8'h05;
      tick();
      src_in = 8'h00;
      wait_irq(10, "rst_first");
      iack = 1'b1;
      tick();
      read_reg(2'd3, d);
      n_cmp++;
      if (d !== 32'h50) begin n_err++; $display("FAIL rst_stat_service: got %h want 50", d); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
      read_reg(2'd0, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL rst_pend: got %h want 00", d); end
      read_reg(2'd1, d);
      n_cmp++;
      if (d !== 32'h00) begin n_err++; $display("FAIL rst_mask: got %h want 00", d); end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         read_reg(2'd3, d);
         if (d !== 32'h40) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL rst_iack_ignored: stat off %0d cycles want 0", bad); end
      iack = 1'b0;
      tick();
   endtask

   initial begin
      rst    = 1'b0;
      src_in = '0;
      iack   = 1'b0;
      wr_en  = 1'b0;
      addr   = 2'd0;
      wdata  = '0;
      test_reset();
      test_edge_basic();
      test_priority();
      test_level();
      test_set_clear_mask();
      test_reset_mid_service();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
